// File: rtl/video_timing_sink_if.sv
// rtl/video_timing_sink_if.sv - ready/valid pixel stream between the streaming stage and the timing sink
interface video_timing_sink_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/video_timing_sink.sv
// rtl/video_timing_sink.sv - raster timing generator that pulls one pixel per active cycle
// and drives a registered data/de/hsync/vsync display interface.
module video_timing_sink #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  video_en,
  video_timing_sink_if.slave    pixel_stream_din,
  output logic [DATA_WIDTH-1:0] video_data,
  output logic                  video_de,
  output logic                  video_hsync,
  output logic                  video_vsync,
  output logic                  frame_start,
  output logic                  underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active;
  logic          hs;
  logic          vs;
  logic          fire;
  logic          at_origin;

  always_comb begin
    active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs        = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
    vs        = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    fire      = pixel_stream_din.valid && pixel_stream_din.ready;
  end

  assign pixel_stream_din.ready = active && video_en;

  // Free-running raster: it never waits on the stream, only video_en parks it at origin.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!video_en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Syncs are gated by video_en so the cycle after disable is already inactive.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      video_data  <= '0;
      video_de    <= 1'b0;
      video_hsync <= ~SYNC_POL;
      video_vsync <= ~SYNC_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      video_data  <= fire ? pixel_stream_din.data : '0;
      video_de    <= active && video_en;
      video_hsync <= (hs && video_en) ? SYNC_POL : ~SYNC_POL;
      video_vsync <= (vs && video_en) ? SYNC_POL : ~SYNC_POL;
      frame_start <= video_en && at_origin;
      if (active && video_en && !pixel_stream_din.valid) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_sink.sv
// tb/tb_video_timing_sink.sv - randomized bench for video_timing_sink against a raster-position model
module tb_video_timing_sink;

  localparam int DW = 8;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          pixel_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic          video_en  = 1'b0;
  logic [DW-1:0] video_data;
  logic          video_de;
  logic          video_hsync;
  logic          video_vsync;
  logic          frame_start;
  logic          underflow;

  video_timing_sink_if #(.DATA_WIDTH(DW)) pixel_stream_din ();

  video_timing_sink #(
    .DATA_WIDTH(DW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .pixel_clk        (pixel_clk),
    .rst_n            (rst_n),
    .video_en         (video_en),
    .pixel_stream_din (pixel_stream_din.slave),
    .video_data       (video_data),
    .video_de         (video_de),
    .video_hsync      (video_hsync),
    .video_vsync      (video_vsync),
    .frame_start      (frame_start),
    .underflow        (underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: linear position in the frame, next pixel value, sticky flag
  int pos         = 0;
  int next_pix    = 0;
  bit m_uf        = 1'b0;
  int fires       = 0;
  bit frame_clean = 1'b0;
  int cycle       = 0;
  int last_fs     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_active(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic bit m_hs(input int p);
    return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
  endfunction

  function automatic bit m_vs(input int p);
    return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
  endfunction

  task automatic step(input bit en, input bit vld);
    bit          act;
    bit          e_fire;
    bit          begin_frame;
    bit          chk_period;
    logic [DW-1:0] pix_b;
    pix_b = next_pix[DW-1:0];
    video_en               = en;
    pixel_stream_din.valid = vld;
    pixel_stream_din.data  = pix_b;
    #1;
    act         = m_active(pos);
    e_fire      = en && act && vld;
    begin_frame = en && (pos == 0);
    chk_period  = begin_frame && frame_clean;
    check_eq("ready", pixel_stream_din.ready, en && act);
    if (begin_frame) begin
      if (frame_clean) check_eq("frame_fires", fires, HA * VA);
      fires       = 0;
      frame_clean = 1'b1;
    end
    if (pixel_stream_din.ready && vld) fires++;
    if (!en) frame_clean = 1'b0;
    if (en && act && !vld) begin
      m_uf        = 1'b1;
      frame_clean = 1'b0;
    end
    @(posedge pixel_clk);
    #1;
    cycle++;
    check_eq("de", video_de, en && act);
    check_eq("data", video_data, e_fire ? pix_b : '0);
    check_eq("hsync", video_hsync, en && m_hs(pos));
    check_eq("vsync", video_vsync, en && m_vs(pos));
    check_eq("frame_start", frame_start, begin_frame);
    check_eq("underflow", underflow, m_uf);
    if (frame_start) begin
      if (chk_period) check_eq("fs_period", cycle - last_fs, FRAME);
      last_fs = cycle;
    end
    if (e_fire) next_pix++;
    pos = en ? (pos + 1) % FRAME : 0;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_de"}, video_de, 1'b0);
    check_eq({tag, "_data"}, video_data, '0);
    check_eq({tag, "_hsync"}, video_hsync, 1'b0);
    check_eq({tag, "_vsync"}, video_vsync, 1'b0);
    check_eq({tag, "_fs"}, frame_start, 1'b0);
    check_eq({tag, "_uf"}, underflow, 1'b0);
  endtask

  initial begin
    pixel_stream_din.valid = 1'b1;
    pixel_stream_din.data  = '0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check_cleared("reset");
    check_eq("reset_ready", pixel_stream_din.ready, 1'b0);
    rst_n = 1'b1;

    // Two-plus clean frames with continuous valid
    for (int i = 0; i < 2 * FRAME + 10; i++) step(1'b1, 1'b1);

    // Enable toggle mid-line, then re-enable at origin
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // One missing pixel at position 5 of the first line
    for (int i = 0; i < FRAME; i++) step(1'b1, pos != 5);
    check_eq("uf_sticky", underflow, 1'b1);

    // Random valid and occasional disable
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0);

    // Async reset pulse between clock edges
    for (int i = 0; i < 37; i++) step(1'b1, 1'b1);
    m_uf = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, pos >= HT);
    #2 rst_n = 1'b0;
    #1 check_cleared("async");
    #2 rst_n = 1'b1;
    pos         = 0;
    m_uf        = 1'b0;
    frame_clean = 1'b0;

    for (int i = 0; i < 2 * FRAME + 20; i++) step(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
